// File: rtl/matmul_pkg.sv
// Shared definitions for the UART matrix-multiply sequencer: the default
// frame header, FSM state encoding and derived-width helpers.
package matmul_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD_A  = 4'd1,
    S_LOAD_B  = 4'd2,
    S_START   = 4'd3,
    S_WAIT_MM = 4'd4,
    S_RD_REQ  = 4'd5,
    S_RD_WAIT = 4'd6,
    S_SEND    = 4'd7,
    S_TX_WAIT = 4'd8
  } state_t;

  // Address width of an NxN row-major memory (at least one bit).
  function automatic int calc_aw(input int n);
    return (n * n <= 1) ? 1 : $clog2(n * n);
  endfunction

  // Width of one dot product of N elements of width dw.
  function automatic int calc_res_w(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  // Number of UART bytes needed to carry one result element.
  function automatic int calc_res_bytes(input int n, input int dw);
    return (calc_res_w(n, dw) + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_matmul_ctrl_rx_byte_event.sv
// Turns the level-style uart_rx ready flag into single-cycle byte events and
// watches the gap between consecutive operand bytes for a stalled sender.
module rx_byte_event #(
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic clk,
  input  logic reset,       // asynchronous, active low
  input  logic i_rx_ready,
  input  logic i_gap_en,    // high only while operand bytes are expected
  output logic o_byte_evt,
  output logic o_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic          r_rx_ready_q;
  logic [CW-1:0] r_gap_cnt;
  logic          w_at_limit;

  // Delayed copy of rx_ready for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rx_ready_q <= 1'b0;
    else        r_rx_ready_q <= i_rx_ready;
  end

  // A flag held high for many cycles still produces exactly one event.
  assign o_byte_evt = i_rx_ready & ~r_rx_ready_q;

  // The counter reads k exactly k cycles after the last byte event, so the
  // abort lands TIMEOUT_CYC cycles after the write that byte caused.
  assign w_at_limit = (r_gap_cnt == CW'(TIMEOUT_CYC - 1));
  assign o_timeout  = i_gap_en & ~o_byte_evt & w_at_limit;

  // Gap counter: cleared by every byte and whenever no operand is pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gap_cnt <= '0;
    end else if (!i_gap_en || o_byte_evt) begin
      r_gap_cnt <= '0;
    end else if (!w_at_limit) begin
      r_gap_cnt <= r_gap_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_matmul_ctrl.sv
// Sequencer between uart_rx/uart_tx and the matrix-multiply core: loads A and
// B from a framed byte stream, starts the multiply, then streams C out MSB
// byte first.
module uart_matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int          N           = 4,
  parameter int          DATA_W      = 8,
  parameter int          TIMEOUT_CYC = 2_000_000,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  localparam int         AW          = calc_aw(N),
  localparam int         RES_W       = calc_res_w(N, DATA_W),
  localparam int         RES_BYTES   = calc_res_bytes(N, DATA_W)
) (
  input  logic              clk,
  input  logic              reset,        // asynchronous, active low
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic              op_wr_en,
  output logic              op_wr_sel,
  output logic [AW-1:0]     op_wr_addr,
  output logic [DATA_W-1:0] op_wr_data,
  output logic              mm_start,
  input  logic              mm_done,
  output logic              res_rd_en,
  output logic [AW-1:0]     res_rd_addr,
  input  logic [RES_W-1:0]  res_rd_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              err
);

  localparam int          SHW  = RES_BYTES * 8;
  localparam int          BCW  = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;
  localparam logic [AW-1:0] LAST = AW'(N * N - 1);

  state_t              r_state;
  logic [AW-1:0]       r_idx;
  logic [BCW-1:0]      r_byte_cnt;
  logic [SHW-1:0]      r_shift;
  logic                r_first;

  logic                r_op_wr_en;
  logic                r_op_wr_sel;
  logic [AW-1:0]       r_op_wr_addr;
  logic [DATA_W-1:0]   r_op_wr_data;
  logic                r_mm_start;
  logic                r_res_rd_en;
  logic [AW-1:0]       r_res_rd_addr;
  logic                r_tx_start;
  logic [7:0]          r_tx_data;
  logic                r_err;

  logic                w_byte_evt;
  logic                w_timeout;
  logic                w_gap_en;

  assign w_gap_en = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);

  rx_byte_event #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx_evt (
    .clk        (clk),
    .reset      (reset),
    .i_rx_ready (rx_ready),
    .i_gap_en   (w_gap_en),
    .o_byte_evt (w_byte_evt),
    .o_timeout  (w_timeout)
  );

  // Main sequencer: strobes default low every cycle, so each one is a
  // single-cycle pulse and at most one is raised per transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_byte_cnt    <= '0;
      r_shift       <= '0;
      r_first       <= 1'b0;
      r_op_wr_en    <= 1'b0;
      r_op_wr_sel   <= 1'b0;
      r_op_wr_addr  <= '0;
      r_op_wr_data  <= '0;
      r_mm_start    <= 1'b0;
      r_res_rd_en   <= 1'b0;
      r_res_rd_addr <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_err         <= 1'b0;
    end else begin
      r_op_wr_en  <= 1'b0;
      r_mm_start  <= 1'b0;
      r_res_rd_en <= 1'b0;
      r_tx_start  <= 1'b0;
      r_err       <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_byte_evt && (rx_data == SYNC_BYTE)) begin
            r_idx   <= '0;
            r_state <= S_LOAD_A;
          end
        end

        S_LOAD_A, S_LOAD_B: begin
          if (w_timeout) begin
            // Abandon the frame; whatever was written stays in memory.
            r_err   <= 1'b1;
            r_idx   <= '0;
            r_state <= S_IDLE;
          end else if (w_byte_evt) begin
            r_op_wr_en   <= 1'b1;
            r_op_wr_sel  <= (r_state == S_LOAD_B);
            r_op_wr_addr <= r_idx;
            r_op_wr_data <= rx_data[DATA_W-1:0];
            if (r_idx == LAST) begin
              r_idx   <= '0;
              r_state <= (r_state == S_LOAD_A) ? S_LOAD_B : S_START;
            end else begin
              r_idx <= r_idx + AW'(1);
            end
          end
        end

        S_START: begin
          r_mm_start <= 1'b1;
          r_state    <= S_WAIT_MM;
        end

        S_WAIT_MM: begin
          // Skip the cycle the start pulse is on the wire so a done level
          // left over from a previous run is not taken as completion.
          if (mm_done && !r_mm_start) begin
            r_idx         <= '0;
            r_res_rd_en   <= 1'b1;
            r_res_rd_addr <= '0;
            r_state       <= S_RD_REQ;
          end
        end

        // The read strobe is already on the port during this state.
        S_RD_REQ: begin
          r_state <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          r_shift    <= SHW'(res_rd_data);
          r_byte_cnt <= BCW'(RES_BYTES - 1);
          r_state    <= S_SEND;
        end

        S_SEND: begin
          if (!tx_busy) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= r_shift[SHW-1 -: 8];
            r_shift    <= r_shift << 8;
            r_first    <= 1'b1;
            r_state    <= S_TX_WAIT;
          end
        end

        S_TX_WAIT: begin
          // uart_tx has not raised busy yet on the cycle tx_start is seen.
          r_first <= 1'b0;
          if (!r_first && !tx_busy) begin
            if (r_byte_cnt != '0) begin
              r_byte_cnt <= r_byte_cnt - BCW'(1);
              r_state    <= S_SEND;
            end else if (r_idx == LAST) begin
              r_idx   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_idx         <= r_idx + AW'(1);
              r_res_rd_en   <= 1'b1;
              r_res_rd_addr <= r_idx + AW'(1);
              r_state       <= S_RD_REQ;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign op_wr_en    = r_op_wr_en;
  assign op_wr_sel   = r_op_wr_sel;
  assign op_wr_addr  = r_op_wr_addr;
  assign op_wr_data  = r_op_wr_data;
  assign mm_start    = r_mm_start;
  assign res_rd_en   = r_res_rd_en;
  assign res_rd_addr = r_res_rd_addr;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign err         = r_err;
  assign busy        = (r_state != S_IDLE);

endmodule
